// File: rtl/riscv_muldiv_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
// The master issues start/funct3/operands; the slave answers with busy/done/result.
interface riscv_muldiv_if #(
    parameter int unsigned WORD_LENGTH = 32
);
    logic                   start;
    logic [2:0]             funct3;
    logic [WORD_LENGTH-1:0] op1;
    logic [WORD_LENGTH-1:0] op2;
    logic                   busy;
    logic                   done;
    logic [WORD_LENGTH-1:0] result;

    modport master (
        output start, funct3, op1, op2,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op1, op2,
        output busy, done, result
    );
endinterface

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Define RISCV_MULDIV_FAST_MUL_EN to compute multiplies in a single cycle with a hardware multiplier.
module riscv_muldiv #(
    parameter int unsigned WORD_LENGTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    riscv_muldiv_if.slave bus
);
    localparam int unsigned W    = WORD_LENGTH;
    localparam int unsigned CntW = $clog2(WORD_LENGTH);

    localparam logic [CntW-1:0] CntLast = CntW'(WORD_LENGTH - 1);
    localparam logic [W-1:0]    MinInt  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]    AllOnes = {W{1'b1}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            neg_q, neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic [W-1:0]    result_q, result_d;

    // Operand decode at issue
    logic         op1_signed, op2_signed;
    logic         op1_neg, op2_neg;
    logic [W-1:0] op1_mag, op2_mag;
    logic         div_by_zero, div_overflow;

    always_comb begin
        op1_signed   = bus.funct3[2] ? ~bus.funct3[0] : ~(bus.funct3[1] & bus.funct3[0]);
        op2_signed   = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
        op1_neg      = op1_signed & bus.op1[W-1];
        op2_neg      = op2_signed & bus.op2[W-1];
        op1_mag      = op1_neg ? -bus.op1 : bus.op1;
        op2_mag      = op2_neg ? -bus.op2 : bus.op2;
        div_by_zero  = bus.funct3[2] & (bus.op2 == '0);
        div_overflow = bus.funct3[2] & ~bus.funct3[0] & (bus.op1 == MinInt) &
                       (bus.op2 == AllOnes);
    end

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    logic [W-1:0]   fast_result;

    // Sign-extending to 2W bits makes the truncated product the exact signed/unsigned product.
    always_comb begin
        fast_a      = {{W{op1_neg}}, bus.op1};
        fast_b      = {{W{op2_neg}}, bus.op2};
        fast_prod   = fast_a * fast_b;
        fast_result = (bus.funct3[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    end
`endif

    // One iteration of the shared core: {hi, lo} is product or {remainder, quotient}
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic [W+1:0]   div_diff;
    logic [W-1:0]   step_hi, step_lo;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   quo_s, rem_s, calc_result;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {W{1'b0}})};
        div_shift = {hi_q, lo_q[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};

        if (funct3_q[2]) begin
            if (!div_diff[W+1]) begin
                step_hi = div_diff[W-1:0];
                step_lo = {lo_q[W-2:0], 1'b1};
            end else begin
                step_hi = div_shift[W-1:0];
                step_lo = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end

        prod   = {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -step_lo : step_lo;
        rem_s  = rem_neg_q ? -step_hi : step_hi;

        case (funct3_q)
            3'b000:                 calc_result = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: calc_result = prod_s[2*W-1:W];
            3'b100, 3'b101:         calc_result = quo_s;
            3'b110, 3'b111:         calc_result = rem_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        funct3_d  = funct3_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    funct3_d  = bus.funct3;
                    neg_d     = op1_neg ^ op2_neg;
                    rem_neg_d = op1_neg;
                    cnt_d     = '0;
                    hi_d      = '0;
                    // Divide: lo holds the dividend; multiply: lo holds the multiplier
                    lo_d      = bus.funct3[2] ? op1_mag : op2_mag;
                    mcand_d   = bus.funct3[2] ? op2_mag : op1_mag;
                    if (div_by_zero) begin
                        result_d = bus.funct3[1] ? bus.op1 : AllOnes;
                        state_d  = StDone;
                    end else if (div_overflow) begin
                        result_d = bus.funct3[1] ? '0 : MinInt;
                        state_d  = StDone;
`ifdef RISCV_MULDIV_FAST_MUL_EN
                    end else if (!bus.funct3[2]) begin
                        result_d = fast_result;
                        state_d  = StDone;
`endif
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    cnt_d    = '0;
                    result_d = calc_result;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            funct3_q  <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            funct3_q  <= funct3_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.result = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv: multiply/divide vectors, special cases,
// busy-start rejection and asynchronous reset abort.
module tb_riscv_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_muldiv_if #(.WORD_LENGTH(32)) bus ();

    riscv_muldiv #(.WORD_LENGTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef RISCV_MULDIV_FAST_MUL_EN
    localparam int MulLat = 0;
`else
    localparam int MulLat = 32;
`endif
    localparam int DivLat  = 32;
    localparam int SpecLat = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // Issue one op; lat counts edges after the accepting edge until done is seen (-1 on timeout).
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_ok,
                         output logic idle_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op1 = a; bus.op2 = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op1 = ~a; bus.op2 = ~b; bus.funct3 = ~f;
        lat = -1; busy_ok = 1'b1; res = '0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i; res = bus.result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        idle_ok = (bus.busy === 1'b0) && (bus.done === 1'b0) && (bus.result === res);
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.funct3 = '0; bus.op1 = '0; bus.op2 = '0;
        #12;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, need 0 0 00000000",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b, need 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_mul;
        logic [2:0]  f   [6];
        logic [31:0] a   [6];
        logic [31:0] b   [6];
        logic [31:0] exp [6];
        logic [31:0] res;
        int lat;
        logic busy_ok, idle_ok;
        f   = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b011};
        a   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
        b   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h10, 32'h10};
        exp = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h2345_6780, 32'h1};
        for (int i = 0; i < 6; i++) begin
            do_op(f[i], a[i], b[i], res, lat, busy_ok, idle_ok);
            n_tests++;
            if (res !== exp[i]) begin
                n_fail++;
                $display("FAIL mul_result[%0d]: got %h need %h", i, res, exp[i]);
            end
            n_tests++;
            if (lat != MulLat) begin
                n_fail++;
                $display("FAIL mul_latency[%0d]: got %0d need %0d", i, lat, MulLat);
            end
            n_tests++;
            if (!busy_ok || !idle_ok) begin
                n_fail++;
                $display("FAIL mul_busy_idle[%0d]: busy_ok=%b idle_ok=%b need 1 1",
                         i, busy_ok, idle_ok);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f   [7];
        logic [31:0] a   [7];
        logic [31:0] b   [7];
        logic [31:0] exp [7];
        logic [31:0] res;
        int lat;
        logic busy_ok, idle_ok;
        f   = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b110};
        a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7, 32'hFFFF_FFF9};
        b   = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            do_op(f[i], a[i], b[i], res, lat, busy_ok, idle_ok);
            n_tests++;
            if (res !== exp[i]) begin
                n_fail++;
                $display("FAIL div_result[%0d]: got %h need %h", i, res, exp[i]);
            end
            n_tests++;
            if (lat != DivLat || !busy_ok || !idle_ok) begin
                n_fail++;
                $display("FAIL div_timing[%0d]: lat=%0d busy_ok=%b idle_ok=%b need %0d 1 1",
                         i, lat, busy_ok, idle_ok, DivLat);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  f   [5];
        logic [31:0] a   [5];
        logic [31:0] b   [5];
        logic [31:0] exp [5];
        logic [31:0] res;
        int lat;
        logic busy_ok, idle_ok;
        f   = '{3'b100, 3'b111, 3'b101, 3'b100, 3'b110};
        a   = '{32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        b   = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        for (int i = 0; i < 5; i++) begin
            do_op(f[i], a[i], b[i], res, lat, busy_ok, idle_ok);
            n_tests++;
            if (res !== exp[i]) begin
                n_fail++;
                $display("FAIL special_result[%0d]: got %h need %h", i, res, exp[i]);
            end
            n_tests++;
            if (lat != SpecLat || !busy_ok || !idle_ok) begin
                n_fail++;
                $display("FAIL special_timing[%0d]: lat=%0d busy_ok=%b idle_ok=%b need %0d 1 1",
                         i, lat, busy_ok, idle_ok, SpecLat);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] res, done_res;
        int lat, first_done, n_done;
        logic busy_ok, idle_ok, held;
        do_op(3'b101, 32'd9, 32'd3, res, lat, busy_ok, idle_ok);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op1 = 32'd100; bus.op2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        first_done = -1; n_done = 0; held = 1'b1; done_res = '0;
        for (int k = 0; k < 45; k++) begin
            if (k == 10) begin
                bus.start = 1'b1; bus.funct3 = 3'b100; bus.op1 = 32'd9; bus.op2 = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                if (first_done < 0) begin
                    first_done = k; done_res = bus.result;
                end
            end else if (first_done < 0 && bus.result !== 32'd3) begin
                held = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        n_tests++;
        if (done_res !== 32'd14) begin
            n_fail++;
            $display("FAIL busy_start_result: got %h need %h", done_res, 32'd14);
        end
        n_tests++;
        if (first_done != DivLat || n_done != 1) begin
            n_fail++;
            $display("FAIL busy_start_done: first=%0d count=%0d need %0d 1",
                     first_done, n_done, DivLat);
        end
        n_tests++;
        if (!held) begin
            n_fail++;
            $display("FAIL result_hold: result changed before done, need 00000003 held");
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] res;
        int lat, n_done;
        logic busy_ok, idle_ok;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.op1 = 32'd1000; bus.op2 = 32'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b result=%h need 0 0 00000000",
                     bus.busy, bus.done, bus.result);
        end
        @(negedge clk); rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        n_tests++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: %0d busy/done cycles seen, need 0", n_done);
        end
        do_op(3'b101, 32'd9, 32'd3, res, lat, busy_ok, idle_ok);
        n_tests++;
        if (res !== 32'd3 || lat != DivLat || !busy_ok || !idle_ok) begin
            n_fail++;
            $display("FAIL abort_recover: res=%h lat=%0d busy_ok=%b idle_ok=%b need 00000003 %0d 1 1",
                     res, lat, busy_ok, idle_ok, DivLat);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_ignored();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
